// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Function : Multi-cycle MIPS multiply/divide unit with architectural HI/LO.
//             MULT/MULTU by shift-add, DIV/DIVU by restoring division,
//             one bit per clock, followed by a sign-fixup/commit cycle.
//  Options  : `define MDU_ABORT_EN adds an 'abort' input that cancels an
//             in-flight operation without touching HI/LO.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
`ifdef MDU_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam logic [COUNT_BITS-1:0] C_LAST = COUNT_BITS'(WIDTH - 1);
    localparam logic [COUNT_BITS-1:0] C_ONE  = COUNT_BITS'(1);

    logic [1:0]           r_state;
    logic [COUNT_BITS-1:0] r_count;
    logic                 r_is_div;
    logic                 r_zero_div;
    logic                 r_neg_q;      // product / quotient must be negated
    logic                 r_neg_r;      // remainder must be negated
    logic [WIDTH-1:0]     r_mag_b;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;        // {upper/remainder, multiplier/quotient}
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_b_zero;
    logic                 w_abort;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

`ifdef MDU_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Operand decode: signed ops work on magnitudes and fix the sign at the end
    always_comb begin
        w_signed = ~op[0];
        w_a_neg  = w_signed & a[WIDTH-1];
        w_b_neg  = w_signed & b[WIDTH-1];
        w_mag_a  = w_a_neg ? -a : a;
        w_mag_b  = w_b_neg ? -b : b;
        w_b_zero = (b == '0);
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_acc[0] ? r_mag_b : {WIDTH{1'b0}})};
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        // Remainder is always below the divisor, so the shift fits WIDTH+1 bits
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
        w_div_diff  = w_div_shift - {1'b0, r_mag_b};
        w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ge};
    end

    // Sign correction applied in the commit cycle
    always_comb begin
        w_prod_fix = r_neg_q ? -r_acc : r_acc;
        w_quot_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, datapath and HI/LO architectural registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_zero_div <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div   <= op[1];
                        r_zero_div <= op[1] & w_b_zero;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_mag_b    <= w_mag_b;
                        r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                        r_count    <= '0;
                        r_state    <= (op[1] & w_b_zero) ? S_FIXUP : S_CALC;
                    end else begin
                        if (hi_write) r_hi <= write_data;
                        if (lo_write) r_lo <= write_data;
                    end
                end
                S_CALC: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= r_is_div ? w_div_next : w_mul_next;
                        r_count <= r_count + C_ONE;
                        if (r_count == C_LAST) r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_state <= S_IDLE;
                    if (!w_abort) begin
                        r_done <= 1'b1;
                        if (r_zero_div) begin
                            r_dbz <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Function : Scoreboard bench for mult_div_unit. Expected HI/LO, flag and
//             latency are queued when an operation is launched and compared
//             when done pulses. Build with +define+MDU_ABORT_EN to add the
//             abort scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    typedef struct {
        logic [63:0] hilo;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] write_data = '0;
`ifdef MDU_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    logic [63:0] m_hilo = '0;

    mult_div_unit #(.WIDTH(32), .COUNT_BITS(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .write_data  (write_data),
`ifdef MDU_ABORT_EN
        .abort       (abort),
`endif
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of MIPS MULT/MULTU/DIV/DIVU; {hi,lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] cur);
        logic signed [63:0] sx, sy, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: model = sx * sy;
            2'b01: model = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) model = cur;
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) model = cur;
                else model = {x % y, x / y};
            end
        endcase
    endfunction

    // Launch one operation and follow it to its done pulse
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp_hilo, input logic exp_dbz,
                         input bit disturb, input bit lo_wr_with_start);
        exp_t        e;
        exp_t        got;
        logic [63:0] prev;
        bit          found;
        int          lat;
        prev   = m_hilo;
        e.hilo = exp_hilo;
        e.dbz  = exp_dbz;
        e.lat  = exp_dbz ? 1 : 33;
        sb.push_back(e);
        m_hilo = exp_hilo;
        op = o; a = x; b = y; start = 1'b1;
        if (lo_wr_with_start) begin
            lo_write   = 1'b1;
            write_data = 32'hDEADBEEF;
        end
        @(posedge clock); #1;
        start = 1'b0; lo_write = 1'b0;
        found = 0;
        lat   = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(posedge clock); #1;
            if (disturb && k == 10) begin
                start = 1'b1; op = ~o; a = 32'h0BADF00D; b = 32'h3;
                hi_write = 1'b1; write_data = 32'hBAD0BAD0;
            end else if (disturb && k == 11) begin
                start = 1'b0; hi_write = 1'b0;
            end
            if (done) begin
                found = 1;
                lat   = k;
                got   = sb.pop_front();
                check("latency", 64'(lat), 64'(got.lat));
                check("hilo", {hi, lo}, got.hilo);
                check("div_by_zero", {63'b0, div_by_zero}, {63'b0, got.dbz});
                check("busy_at_done", {63'b0, busy}, 64'd0);
            end else begin
                check("busy_mid", {63'b0, busy}, 64'd1);
                check("hilo_hold", {hi, lo}, prev);
                check("dbz_idle", {63'b0, div_by_zero}, 64'd0);
            end
        end
        if (!found) begin
            check("done_timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
        end
        @(posedge clock); #1;
        check("done_one_cycle", {62'b0, done, div_by_zero}, 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_flags", {61'b0, busy, done, div_by_zero}, 64'd0);

        do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 0, 0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 0, 0);
        do_op(2'b11, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 0, 0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 0, 0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 0, 0);

        // Preload HI/LO, then divide by zero must leave them alone
        hi_write = 1'b1; write_data = 32'h11111111;
        @(posedge clock); #1;
        hi_write = 1'b0; lo_write = 1'b1; write_data = 32'h22222222;
        @(posedge clock); #1;
        lo_write = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'h11111111_22222222);
        m_hilo = 64'h11111111_22222222;
        do_op(2'b10, 32'd55, 32'd0, 64'h11111111_22222222, 1'b1, 0, 0);

        // lo_write alongside start is dropped (visible because b == 0)
        do_op(2'b11, 32'd9, 32'd0, 64'h11111111_22222222, 1'b1, 0, 1);

        // New start and hi_write while busy are ignored
        do_op(2'b01, 32'd12345, 32'd6789, model(2'b01, 32'd12345, 32'd6789, m_hilo), 1'b0, 1, 0);

        // A few pseudo-random operations against the model
        for (int i = 0; i < 6; i++) begin
            ro = 2'(i % 4);
            rx = $urandom;
            ry = (i == 5) ? 32'hFFFFFFFF : $urandom;
            if (ro[1] && ry == 0) ry = 32'd1;
            do_op(ro, rx, ry, model(ro, rx, ry, m_hilo), 1'b0, 0, 0);
        end

        // Reset in the middle of a multiply discards it
        op = 2'b00; a = 32'd1000; b = 32'd1000; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        m_hilo = '0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) seen = 1;
        end
        check("midrst_no_done", {63'b0, seen}, 64'd0);
        do_op(2'b00, 32'd6, 32'd7, 64'h00000000_0000002A, 1'b0, 0, 0);

`ifdef MDU_ABORT_EN
        // Abort in CALC returns to IDLE with HI/LO untouched and no done
        op = 2'b01; a = 32'd77; b = 32'd99; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1;
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, m_hilo);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) seen = 1;
        end
        check("abort_no_done", {63'b0, seen}, 64'd0);
        check("abort_hilo_end", {hi, lo}, m_hilo);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time bound expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
